// File: rtl/ring_pkg.sv
// ring_pkg: ring slot types, field widths and barrier master FSM states shared by ring nodes.
package ring_pkg;
  localparam int DATA_W = 32;
  localparam int SLOT_W = 4;
  localparam int ADDR_W = 4;
  localparam logic [SLOT_W-1:0] SLOT_TOKEN       = 4'd1;
  localparam logic [SLOT_W-1:0] SLOT_NULL        = 4'd7;
  localparam logic [SLOT_W-1:0] SLOT_BARRIER     = 4'd13;
  localparam logic [SLOT_W-1:0] SLOT_BARRIER_REL = 4'd14;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_TOKEN, S_WAIT_N, S_SEND} bm_state_t;
endpackage

// File: rtl/barrier_counter_bank.sv
// barrier_counter_bank: per-ID arrival counters, pending-release bits, sticky overflow and lowest-pending encoder.
module barrier_counter_bank #(
  parameter int NUM_BAR = 8,
  parameter int CW = 4,
  parameter int IDW = $clog2(NUM_BAR)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_arrive,
  input  logic [IDW-1:0] i_id,
  input  logic [CW-1:0]  i_num_cores,
  input  logic           i_clear,
  output logic           o_pend_any,
  output logic [IDW-1:0] o_rel_id,
  output logic           o_overflow
);
  logic [CW-1:0] r_cnt [NUM_BAR];
  logic [NUM_BAR-1:0] r_pend;
  logic r_ovf;
  logic [CW-1:0] w_need, w_inc;
  logic w_done, w_clr_hit;
  assign w_need = (i_num_cores == '0) ? CW'(1) : i_num_cores;
  assign w_inc = r_cnt[i_id] + CW'(1);
  assign w_done = w_inc >= w_need;
  assign w_clr_hit = i_clear && (o_rel_id == i_id);
  assign o_pend_any = |r_pend;
  assign o_overflow = r_ovf;
  always_comb begin
    o_rel_id = '0;
    for (int k = NUM_BAR - 1; k >= 0; k--)
      if (r_pend[k]) o_rel_id = k[IDW-1:0];
  end
  // Set is applied after clear so a completing arrival on the released ID wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '{default: '0};
      r_pend <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_clear) r_pend[o_rel_id] <= 1'b0;
      if (i_arrive) begin
        if (w_done) begin
          r_cnt[i_id] <= '0;
          r_pend[i_id] <= 1'b1;
          if (r_pend[i_id] && !w_clr_hit) r_ovf <= 1'b1;
        end else begin
          r_cnt[i_id] <= w_inc;
        end
      end
    end
  end
endmodule

// File: rtl/barrier_master.sv
// barrier_master: ring node that counts barrier arrivals per ID and broadcasts a release once it holds the token.
module barrier_master
  import ring_pkg::*;
#(
  parameter int NUM_BAR = 8,
  parameter int CW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] whichCore,
  input  logic [CW-1:0]     numCores,
  input  logic [DATA_W-1:0] RingIn,
  input  logic [SLOT_W-1:0] SlotTypeIn,
  input  logic [ADDR_W-1:0] SrcDestIn,
  input  logic              otherWaiting,
  output logic [DATA_W-1:0] masterRingOut,
  output logic [SLOT_W-1:0] masterSlotTypeOut,
  output logic [ADDR_W-1:0] masterSrcDestOut,
  output logic              masterDriveRing,
  output logic              masterWaiting,
  output logic              overflowErr
);
  localparam int IDW = $clog2(NUM_BAR);
  localparam logic [5:0] ID_LIMIT = 6'(NUM_BAR);
  bm_state_t r_state, w_next;
  logic [7:0] r_burst;
  logic w_arrive, w_ret, w_take, w_send, w_pend_any;
  logic [IDW-1:0] w_rel_id;
  assign w_arrive = (SlotTypeIn == SLOT_BARRIER) && (RingIn[5:0] < ID_LIMIT);
  assign w_ret = (SlotTypeIn == SLOT_BARRIER_REL) && (SrcDestIn == whichCore);
  assign w_take = (r_state == S_WAIT_TOKEN) && (SlotTypeIn == SLOT_TOKEN) && !otherWaiting;
  assign w_send = r_state == S_SEND;
  barrier_counter_bank #(.NUM_BAR(NUM_BAR), .CW(CW)) u_bank (
    .clock(clock),
    .reset(reset),
    .i_arrive(w_arrive),
    .i_id(RingIn[IDW-1:0]),
    .i_num_cores(numCores),
    .i_clear(w_send),
    .o_pend_any(w_pend_any),
    .o_rel_id(w_rel_id),
    .o_overflow(overflowErr)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      r_burst <= w_take ? RingIn[7:0] : (r_state == S_WAIT_N) ? r_burst - 8'd1 : r_burst;
    end
  end
  // A zero-length train means the very next slot is free for the release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = w_pend_any ? S_WAIT_TOKEN : S_IDLE;
      S_WAIT_TOKEN: w_next = !w_take ? S_WAIT_TOKEN : (RingIn[7:0] == 8'd0) ? S_SEND : S_WAIT_N;
      S_WAIT_N:     w_next = (r_burst == 8'd1) ? S_SEND : S_WAIT_N;
      default:      w_next = S_IDLE;
    endcase
  end
  always_comb begin
    masterDriveRing = w_send | w_take | w_arrive | w_ret;
    masterWaiting = r_state == S_WAIT_TOKEN;
    masterSlotTypeOut = w_send ? SLOT_BARRIER_REL : w_take ? SLOT_TOKEN : (w_arrive | w_ret) ? SLOT_NULL : SlotTypeIn;
    masterRingOut = w_send ? {{(DATA_W-IDW){1'b0}}, w_rel_id} : w_take ? RingIn + 32'd1 : (w_arrive | w_ret) ? '0 : RingIn;
    masterSrcDestOut = w_send ? whichCore : SrcDestIn;
  end
endmodule

// File: tb/tb_barrier_master.sv
// tb_barrier_master: scoreboard bench; each driven cycle queues its expected outputs, checked at the falling edge.
module tb_barrier_master;
  localparam logic [3:0] T = 4'd1, N = 4'd7, B = 4'd13, R = 4'd14, W = 4'd9;
  logic clock = 0, reset = 1;
  logic [3:0] whichCore = W, numCores = 4'd3;
  logic [31:0] RingIn = 0;
  logic [3:0] SlotTypeIn = N, SrcDestIn = 0;
  logic otherWaiting = 0;
  logic [31:0] masterRingOut;
  logic [3:0] masterSlotTypeOut, masterSrcDestOut;
  logic masterDriveRing, masterWaiting, overflowErr;
  int n_chk = 0, n_err = 0;
  logic exp_ovf = 0;
  typedef struct { string tag; logic [42:0] v; } exp_t;
  exp_t q[$];

  barrier_master dut (
    .clock(clock), .reset(reset), .whichCore(whichCore), .numCores(numCores),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn), .otherWaiting(otherWaiting),
    .masterRingOut(masterRingOut), .masterSlotTypeOut(masterSlotTypeOut), .masterSrcDestOut(masterSrcDestOut),
    .masterDriveRing(masterDriveRing), .masterWaiting(masterWaiting), .overflowErr(overflowErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // fields: {drive, waiting, overflow, slot, srcdest, data}
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, 64'({masterDriveRing, masterWaiting, overflowErr, masterSlotTypeOut, masterSrcDestOut, masterRingOut}), 64'(e.v));
    end
  end

  task automatic drv(input string tag, input logic [31:0] ring, input logic [3:0] st, input logic [3:0] sd,
                     input logic ow, input logic dr, input logic [3:0] est, input logic [3:0] esd,
                     input logic [31:0] edata, input logic ew);
    @(posedge clock);
    #1;
    RingIn = ring; SlotTypeIn = st; SrcDestIn = sd; otherWaiting = ow;
    q.push_back('{tag, {dr, ew, exp_ovf, est, esd, edata}});
  endtask

  task automatic pass(input string tag, input logic [31:0] ring, input logic [3:0] st, input logic [3:0] sd,
                      input logic ow, input logic ew);
    drv(tag, ring, st, sd, ow, 1'b0, st, sd, ring, ew);
  endtask

  task automatic idle(input string tag, input logic ew);
    pass(tag, 32'h0, N, 4'd0, 1'b0, ew);
  endtask

  task automatic arr(input string tag, input logic [31:0] id, input logic [3:0] core, input logic ew);
    drv(tag, id, B, core, 1'b0, 1'b1, N, core, 32'h0, ew);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    pass("rst_pass", 32'hA5A5_0055, 4'd3, 4'd2, 1'b0, 1'b0);
    pass("idle_tok", 32'd5, T, 4'd1, 1'b0, 1'b0);
    numCores = 4'd3;
    arr("a2_c1", 2, 4'd1, 0); arr("a2_c4", 2, 4'd4, 0); arr("a2_c5", 2, 4'd5, 0);
    idle("t1_pend", 0); idle("t1_wait", 1);
    drv("t1_tok", 0, T, 4'd3, 0, 1, T, 4'd3, 32'd1, 1);
    drv("t1_rel", 0, N, 4'd0, 0, 1, R, W, 32'd2, 0);
    idle("t1_idle", 0);
    drv("t1_ret", 2, R, W, 0, 1, N, W, 32'd0, 0);
    pass("t1_foreign_rel", 2, R, 4'd3, 0, 0);
    numCores = 4'd0;
    arr("a3", 3, 4'd2, 0); idle("t2_pend", 0); idle("t2_wait", 1);
    drv("t2_tok", 3, T, 4'd1, 0, 1, T, 4'd1, 32'd4, 1);
    pass("t2_tr0", 32'h11, 4'd2, 4'd1, 0, 0);
    pass("t2_tr1", 32'h22, 4'd2, 4'd1, 0, 0);
    pass("t2_tr2", 32'h33, 4'd2, 4'd1, 0, 0);
    drv("t2_rel", 0, N, 4'd0, 0, 1, R, W, 32'd3, 0);
    drv("t2_ret", 3, R, W, 0, 1, N, W, 32'd0, 0);
    numCores = 4'd1;
    arr("a5", 5, 4'd6, 0); arr("a1", 1, 4'd7, 0); idle("t3_wait", 1);
    drv("t3_tok1", 0, T, 4'd0, 0, 1, T, 4'd0, 32'd1, 1);
    drv("t3_rel1", 0, N, 4'd0, 0, 1, R, W, 32'd1, 0);
    idle("t3_idle", 0); idle("t3_wait2", 1);
    drv("t3_tok2", 0, T, 4'd0, 0, 1, T, 4'd0, 32'd1, 1);
    drv("t3_rel5", 0, N, 4'd0, 0, 1, R, W, 32'd5, 0);
    idle("t3_done", 0);
    arr("a4", 4, 4'd2, 0); idle("t4_pend", 0); idle("t4_wait", 1);
    pass("t4_tok_ow", 0, T, 4'd3, 1, 1);
    drv("t4_tok", 0, T, 4'd3, 0, 1, T, 4'd3, 32'd1, 1);
    drv("t4_rel", 0, N, 4'd0, 0, 1, R, W, 32'd4, 0);
    idle("t4_done", 0);
    arr("a0_1", 0, 4'd1, 0); arr("a0_2", 0, 4'd2, 0);
    exp_ovf = 1;
    idle("t5_ovf", 1);
    drv("t5_tok", 0, T, 4'd0, 0, 1, T, 4'd0, 32'd1, 1);
    drv("t5_rel", 0, N, 4'd0, 0, 1, R, W, 32'd0, 0);
    idle("t5_idle", 0); idle("t5_single", 0);
    pass("a40", 32'd40, B, 4'd3, 0, 0);
    idle("t5_a40_none", 0); idle("t5_a40_none2", 0);
    arr("a6", 6, 4'd1, 0); idle("t6_pend", 0); idle("t6_wait", 1);
    drv("t6_tok", 5, T, 4'd2, 0, 1, T, 4'd2, 32'd6, 1);
    pass("t6_n1", 32'h44, 4'd2, 4'd1, 0, 0);
    reset = 1;
    exp_ovf = 0;
    idle("t6_rst", 0);
    reset = 0;
    repeat (8) idle("t6_quiet", 0);
    @(negedge clock);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
